// File: rtl/verifla_pkg.sv
// Shared definitions for the VeriFLA run-trigger arbitration logic.
package verifla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_BUSY = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/req_pulse_of_verifla.sv
// Level-to-single-pulse converter: one registered pulse per assertion of req.
module req_pulse_of_verifla (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic pulse
);

  logic armed_q, armed_d;
  logic pulse_q, pulse_d;

  always_comb begin
    pulse_d = req & ~armed_q;
    armed_d = req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/run_arbiter_of_verifla.sv
// Round-robin arbiter sharing the logic-analyser run trigger among NREQ requesters,
// tracking the monitor's busy handshake through to done or timeout.
module run_arbiter_of_verifla
  import verifla_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     la_busy,
  output logic                     run,
  output logic                     grant_valid,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     done,
  output logic                     timeout_err,
  output logic [NREQ-1:0]          pending
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0] pulse;

  for (genvar i = 0; i < NREQ; i++) begin : g_pulse
    req_pulse_of_verifla u_pulse (
      .clk   (clk),
      .reset (reset),
      .req   (req[i]),
      .pulse (pulse[i])
    );
  end

  state_e          state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d, grant_clr;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            run_q, run_d;
  logic            grant_valid_q, grant_valid_d;
  logic            done_q, done_d;
  logic            timeout_err_q, timeout_err_d;

  logic [IDW-1:0]  pick_idx;
  logic            pick_found;
  int unsigned     cand;

  // Scan starts just past the last winner; wrap by subtraction keeps it divider-free.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pick_found && pending_q[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    to_cnt_d      = to_cnt_q;
    run_d         = 1'b0;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    grant_clr     = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found && !la_busy) begin
          run_d               = 1'b1;
          grant_valid_d       = 1'b1;
          grant_id_d          = pick_idx;
          rr_ptr_d            = pick_idx;
          grant_clr[pick_idx] = 1'b1;
          to_cnt_d            = '0;
          state_d             = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (la_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!la_busy) begin
          done_d        = 1'b1;
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase

    // A fresh pulse on the bit being granted this cycle stays pending.
    pending_d = (pending_q & ~grant_clr) | pulse;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= IDW'(NREQ - 1);
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      to_cnt_q      <= '0;
      run_q         <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      to_cnt_q      <= to_cnt_d;
      run_q         <= run_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign run         = run_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign pending     = pending_q;

endmodule
